multicycle_controller: RTL and testbench

Main control unit for the multicycle RV32I core. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the datapath selects, the write enables, the ALU operation and the `immSrc` code consumed by the immediate sign-extender. Supported instructions: lw, sw, R-type ALU (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, bne, jal.

---
 rtl/multicycle_controller_if.sv | 33 +++
 rtl/multicycle_controller.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Instruction fields in, datapath controls out, between the multicycle
// controller (master) and the datapath (slave).
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic [1:0] immSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic       adrSrc;
    logic [2:0] aluControl;
    logic       irWrite;
    logic       pcWrite;
    logic       regWrite;
    logic       memWrite;
    logic       instrDone;
    logic       illegalOp;

    modport master (
        input  op, funct3, funct7b5, zero,
        output immSrc, aluSrcA, aluSrcB, resultSrc, adrSrc, aluControl,
               irWrite, pcWrite, regWrite, memWrite, instrDone, illegalOp
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  immSrc, aluSrcA, aluSrcB, resultSrc, adrSrc, aluControl,
               irWrite, pcWrite, regWrite, memWrite, instrDone, illegalOp
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback and decodes the datapath controls.
module multicycle_controller (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.master       bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RALU = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t  state_q;
    state_t  state_d;
    alu_op_t alu_op_s;
    logic    branch_s;
    logic    pc_update_s;
    logic    ir_write_s;
    logic    reg_write_s;
    logic    mem_write_s;
    logic    instr_done_s;
    logic    illegal_op_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] result_src_s;
    logic       adr_src_s;

    function automatic logic [1:0] imm_decode(input logic [6:0] op);
        case (op)
            OP_LW, OP_IALU: imm_decode = 2'b00;
            OP_SW:          imm_decode = 2'b01;
            OP_BR:          imm_decode = 2'b10;
            OP_JAL:         imm_decode = 2'b11;
            default:        imm_decode = 2'b00;
        endcase
    endfunction

    // addi never subtracts: only R-type (op[5]=1) honours funct7b5.
    function automatic logic [2:0] alu_decode(input alu_op_t aop, input logic op5,
                                              input logic [2:0] f3, input logic f7b5);
        case (aop)
            ALU_ADD: alu_decode = 3'b000;
            ALU_SUB: alu_decode = 3'b001;
            ALU_FUNCT: begin
                case (f3)
                    3'b000:  alu_decode = (op5 & f7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_decode = 3'b101;
                    3'b110:  alu_decode = 3'b011;
                    3'b111:  alu_decode = 3'b010;
                    default: alu_decode = 3'b000;
                endcase
            end
            default: alu_decode = 3'b000;
        endcase
    endfunction

    // State register; reset returns to FETCH without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state Moore controls.
    always_comb begin
        state_d      = state_q;
        alu_op_s     = ALU_ADD;
        branch_s     = 1'b0;
        pc_update_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        instr_done_s = 1'b0;
        illegal_op_s = 1'b0;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        result_src_s = 2'b00;
        adr_src_s    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_s   = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                pc_update_s  = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RALU:      state_d = S_EXECUTER;
                    OP_IALU:      state_d = S_EXECUTEI;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal_op_s = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (bus.op[5]) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
                state_d   = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_s    = 1'b1;
                mem_write_s  = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = ALU_FUNCT;
                state_d     = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = ALU_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s  = 2'b10;
                alu_op_s     = ALU_SUB;
                branch_s     = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_update_s = 1'b1;
                state_d     = S_ALUWB;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Output drive; enables are suppressed while reset is held.
    always_comb begin
        bus.immSrc     = imm_decode(bus.op);
        bus.aluSrcA    = alu_src_a_s;
        bus.aluSrcB    = alu_src_b_s;
        bus.resultSrc  = result_src_s;
        bus.adrSrc     = adr_src_s;
        bus.aluControl = alu_decode(alu_op_s, bus.op[5], bus.funct3, bus.funct7b5);
        bus.irWrite    = ir_write_s & ~reset;
        bus.pcWrite    = (pc_update_s | (branch_s & (bus.zero ^ bus.funct3[0]))) & ~reset;
        bus.regWrite   = reg_write_s & ~reset;
        bus.memWrite   = mem_write_s & ~reset;
        bus.instrDone  = instr_done_s & ~reset;
        bus.illegalOp  = illegal_op_s & ~reset;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table,
// reset corner cases, and randomized instruction streams against a model.
module tb_multicycle_controller;

    logic clk;
    logic reset;
    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector: {immSrc, aluSrcA, aluSrcB, resultSrc, adrSrc, aluControl,
    //                 irWrite, pcWrite, regWrite, memWrite, instrDone, illegalOp}
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RA = 7'b0110011;
    localparam logic [6:0] IA = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
    localparam logic [17:0] RESET_VEC = {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 6'b000000};

    int n_checks = 0;
    int n_fail   = 0;
    logic [17:0] got;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        zero;
        int          len;
        int          chk;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [17:0] sample();
        return {bus.immSrc, bus.aluSrcA, bus.aluSrcB, bus.resultSrc, bus.adrSrc,
                bus.aluControl, bus.irWrite, bus.pcWrite, bus.regWrite,
                bus.memWrite, bus.instrDone, bus.illegalOp};
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Called just after a rising edge: drive, sample mid-cycle, advance.
    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
        @(negedge clk);
        got = sample();
        @(posedge clk);
        #1;
    endtask

    // Reference: each instruction is a fixed list of steps named after the
    // spec's states; outputs come straight from the per-state table.
    function automatic int instr_len(input logic [6:0] op);
        case (op)
            LW:                 return 5;
            SW, RA, IA, JL:     return 4;
            BR:                 return 3;
            default:            return 2;
        endcase
    endfunction

    function automatic logic [17:0] model_out(input logic [6:0] op, input logic [2:0] f3,
                                              input logic f7, input logic z, input int stp);
        string ph;
        logic [1:0] imm, a, b, res;
        logic adr, ir, upd, brn, rw, mw, done, ill;
        logic [2:0] alu;
        int kind; // 0 add, 1 sub, 2 funct
        imm = (op == SW) ? 2'b01 : (op == BR) ? 2'b10 : (op == JL) ? 2'b11 : 2'b00;
        if (stp == 0) ph = "F";
        else if (stp == 1) ph = "D";
        else if (op == LW) ph = (stp == 2) ? "MA" : (stp == 3) ? "MR" : "MWB";
        else if (op == SW) ph = (stp == 2) ? "MA" : "MW";
        else if (op == RA) ph = (stp == 2) ? "ER" : "WB";
        else if (op == IA) ph = (stp == 2) ? "EI" : "WB";
        else if (op == JL) ph = (stp == 2) ? "J" : "WB";
        else ph = "BR";
        a = 2'b00; b = 2'b00; res = 2'b00; adr = 1'b0; ir = 1'b0; upd = 1'b0;
        brn = 1'b0; rw = 1'b0; mw = 1'b0; done = 1'b0; ill = 1'b0; kind = 0;
        if (ph == "F")   begin ir = 1'b1; b = 2'b10; res = 2'b10; upd = 1'b1; end
        if (ph == "D")   begin a = 2'b01; b = 2'b01; ill = (instr_len(op) == 2); end
        if (ph == "MA")  begin a = 2'b10; b = 2'b01; end
        if (ph == "MR")  adr = 1'b1;
        if (ph == "MWB") begin res = 2'b01; rw = 1'b1; done = 1'b1; end
        if (ph == "MW")  begin adr = 1'b1; mw = 1'b1; done = 1'b1; end
        if (ph == "ER")  begin a = 2'b10; kind = 2; end
        if (ph == "EI")  begin a = 2'b10; b = 2'b01; kind = 2; end
        if (ph == "WB")  begin rw = 1'b1; done = 1'b1; end
        if (ph == "BR")  begin a = 2'b10; kind = 1; brn = 1'b1; done = 1'b1; end
        if (ph == "J")   begin a = 2'b01; b = 2'b10; upd = 1'b1; end
        if (kind == 1) alu = 3'b001;
        else if (kind == 0) alu = 3'b000;
        else if (f3 == 3'b000) alu = (op[5] && f7) ? 3'b001 : 3'b000;
        else if (f3 == 3'b010) alu = 3'b101;
        else if (f3 == 3'b110) alu = 3'b011;
        else if (f3 == 3'b111) alu = 3'b010;
        else alu = 3'b000;
        return {imm, a, b, res, adr, alu, ir, upd | (brn & (z ^ f3[0])), rw, mw, done, ill};
    endfunction

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int first);
        logic z;
        for (int s = first; s < instr_len(op); s++) begin
            z = 1'($urandom_range(0, 1));
            step(op, f3, f7, z);
            check($sformatf("model op=%b f3=%b step=%0d", op, f3, s), got,
                  model_out(op, f3, f7, z, s));
        end
    endtask

    initial begin
        logic [6:0] ops[6];
        logic [6:0] rop;
        ops = '{LW, SW, RA, IA, BR, JL};

        vecs[0]  = '{"lw_memwb",   LW, 3'b010, 1'b0, 1'b0, 5, 5, {2'b00,2'b00,2'b00,2'b01,1'b0,3'b000,6'b001010}};
        vecs[1]  = '{"lw_fetch",   LW, 3'b010, 1'b0, 1'b0, 5, 1, {2'b00,2'b00,2'b10,2'b10,1'b0,3'b000,6'b110000}};
        vecs[2]  = '{"sw_memwr",   SW, 3'b010, 1'b0, 1'b0, 4, 4, {2'b01,2'b00,2'b00,2'b00,1'b1,3'b000,6'b000110}};
        vecs[3]  = '{"r_sub",      RA, 3'b000, 1'b1, 1'b0, 4, 3, {2'b00,2'b10,2'b00,2'b00,1'b0,3'b001,6'b000000}};
        vecs[4]  = '{"r_add",      RA, 3'b000, 1'b0, 1'b0, 4, 3, {2'b00,2'b10,2'b00,2'b00,1'b0,3'b000,6'b000000}};
        vecs[5]  = '{"r_slt",      RA, 3'b010, 1'b0, 1'b0, 4, 3, {2'b00,2'b10,2'b00,2'b00,1'b0,3'b101,6'b000000}};
        vecs[6]  = '{"addi_f7",    IA, 3'b000, 1'b1, 1'b0, 4, 3, {2'b00,2'b10,2'b01,2'b00,1'b0,3'b000,6'b000000}};
        vecs[7]  = '{"ori",        IA, 3'b110, 1'b0, 1'b0, 4, 3, {2'b00,2'b10,2'b01,2'b00,1'b0,3'b011,6'b000000}};
        vecs[8]  = '{"andi",       IA, 3'b111, 1'b0, 1'b0, 4, 3, {2'b00,2'b10,2'b01,2'b00,1'b0,3'b010,6'b000000}};
        vecs[9]  = '{"beq_taken",  BR, 3'b000, 1'b0, 1'b1, 3, 3, {2'b10,2'b10,2'b00,2'b00,1'b0,3'b001,6'b010010}};
        vecs[10] = '{"beq_not",    BR, 3'b000, 1'b0, 1'b0, 3, 3, {2'b10,2'b10,2'b00,2'b00,1'b0,3'b001,6'b000010}};
        vecs[11] = '{"bne_taken",  BR, 3'b001, 1'b0, 1'b0, 3, 3, {2'b10,2'b10,2'b00,2'b00,1'b0,3'b001,6'b010010}};
        vecs[12] = '{"jal_jal",    JL, 3'b000, 1'b0, 1'b0, 4, 3, {2'b11,2'b01,2'b10,2'b00,1'b0,3'b000,6'b010000}};
        vecs[13] = '{"jal_aluwb",  JL, 3'b000, 1'b0, 1'b0, 4, 4, {2'b11,2'b00,2'b00,2'b00,1'b0,3'b000,6'b001010}};
        vecs[14] = '{"illegal",    7'b1111111, 3'b000, 1'b0, 1'b0, 2, 2, {2'b00,2'b01,2'b01,2'b00,1'b0,3'b000,6'b000001}};
        vecs[15] = '{"decode_lw",  LW, 3'b010, 1'b0, 1'b0, 5, 2, {2'b00,2'b01,2'b01,2'b00,1'b0,3'b000,6'b000000}};

        reset = 1'b1;
        bus.op = LW; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
        @(posedge clk);
        #1;
        check("reset_state", sample(), RESET_VEC);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            for (int c = 1; c <= vecs[i].len; c++) begin
                step(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].zero);
                if (c == vecs[i].chk) check(vecs[i].name, got, vecs[i].exp);
            end
        end

        // Illegal op returns straight to FETCH.
        step(LW, 3'b000, 1'b0, 1'b0);
        check("after_illegal_fetch", got, model_out(LW, 3'b000, 1'b0, 1'b0, 0));
        step(LW, 3'b000, 1'b0, 1'b0);
        run_instr(LW, 3'b000, 1'b0, 2);

        // Asynchronous reset while in MEMREAD.
        run_instr(LW, 3'b010, 1'b0, 0);
        for (int s = 0; s < 3; s++) step(LW, 3'b010, 1'b0, 1'b0);
        check("pre_reset_memread", sample(), model_out(LW, 3'b010, 1'b0, 1'b0, 3));
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_fetch", sample(), RESET_VEC);
        @(negedge clk);
        check("reset_hold_enables", sample(), RESET_VEC);
        #1;
        reset = 1'b0;
        #1;
        check("release_full_fetch", sample(), model_out(LW, 3'b010, 1'b0, 1'b0, 0));
        @(posedge clk);
        #1;
        run_instr(LW, 3'b010, 1'b0, 1);

        // Randomized instruction stream.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) < 8) rop = ops[$urandom_range(0, 5)];
            else rop = 7'($urandom());
            run_instr(rop, 3'($urandom()), 1'($urandom()), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
